// File: rtl/memctrl_pkg.sv
// memctrl_pkg
// Shared constants and decode helper for the load/store memory controller.
//   OP_LDR / OP_STR : opcodes that start a memory access; all others are NOP
//   RW_READ/RW_WRITE: encoding of the RW bus control
//   WORD_W          : data word width (full 32-bit words only)
// Optional feature macro used by the controller: MEMCTRL_ALIGN_CHECK_EN
package memctrl_pkg;

  localparam int          WORD_W   = 32;
  localparam logic [3:0]  OP_LDR   = 4'b1101;
  localparam logic [3:0]  OP_STR   = 4'b1110;
  localparam logic        RW_READ  = 1'b1;
  localparam logic        RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    ACC_NOP = 2'd0,
    ACC_LDR = 2'd1,
    ACC_STR = 2'd2
  } access_e;

  // Map a raw opcode onto the kind of access it requests
  function automatic access_e decodeOp(input logic [3:0] op);
    access_e kind;
    kind = ACC_NOP;
    if (op == OP_LDR) kind = ACC_LDR;
    else if (op == OP_STR) kind = ACC_STR;
    return kind;
  endfunction

endpackage

// File: rtl/memctrl_ram.sv
// memctrl_ram
// Word-addressed single-port data RAM with registered read and
// asynchronous clear of every word.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low clear (contents and read register)
//   we    : write enable, writes wdata to mem[addr] on the clock edge
//   re    : read enable, loads rdata from mem[addr]; rdata holds otherwise
//   addr  : word index
//   wdata : write data
//   rdata : registered read data
module memctrl_ram
  import memctrl_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Storage and read register; the whole array clears on reset so a load
  // after reset always returns zero. rdata only moves on a read, which lets
  // the controller use it directly as a value that holds between loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rdata <= '0;
    end else begin
      if (we) begin
        mem[addr] <= wdata;
      end
      if (re) begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/memory_controller.sv
// memory_controller
// Decodes LDR/STR opcodes each cycle, registers the external bus controls
// and services the access against an internal data RAM (1-cycle latency).
// Optional feature macro: MEMCTRL_ALIGN_CHECK_EN adds AlignErr and turns
// misaligned accesses into NOPs.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   Opcode           : 4'b1101 LDR, 4'b1110 STR, anything else NOP
//   Address, Data    : byte address and store data of the access
//   LDRSel           : write-back mux takes load data
//   AddressBusSel    : this block drives the address bus
//   RW               : 1 read, 0 write
//   LDRDataToDestReg : load result, holds between loads
//   AddressBus       : registered Address during an access, else 0
//   DataBus          : registered Data during STR, else 0
//   AlignErr         : (MEMCTRL_ALIGN_CHECK_EN only) misaligned access flag
module memory_controller
  import memctrl_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        Opcode,
  input  logic [31:0]       Address,
  input  logic [WORD_W-1:0] Data,
  output logic              LDRSel,
  output logic              AddressBusSel,
  output logic              RW,
  output logic [WORD_W-1:0] LDRDataToDestReg,
  output logic [31:0]       AddressBus,
  output logic [WORD_W-1:0] DataBus
`ifdef MEMCTRL_ALIGN_CHECK_EN
  ,
  output logic              AlignErr
`endif
);

  access_e       kind;
  logic          doLdr;
  logic          doStr;
  logic [AW-1:0] idx;

  // Upper address bits are dropped, so addresses alias modulo DEPTH*4
  assign idx = Address[AW+1:2];

  // Effective access for this cycle; a misaligned access is squashed to a
  // NOP when the alignment check is built in
  always_comb begin
    kind  = decodeOp(Opcode);
    doLdr = (kind == ACC_LDR);
    doStr = (kind == ACC_STR);
`ifdef MEMCTRL_ALIGN_CHECK_EN
    if (Address[1:0] != 2'b00) begin
      doLdr = 1'b0;
      doStr = 1'b0;
    end
`endif
  end

  // Bus control registers, rebuilt from scratch every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      LDRSel        <= 1'b0;
      AddressBusSel <= 1'b0;
      RW            <= RW_READ;
      AddressBus    <= '0;
      DataBus       <= '0;
    end else begin
      LDRSel        <= doLdr;
      AddressBusSel <= doLdr | doStr;
      RW            <= doStr ? RW_WRITE : RW_READ;
      AddressBus    <= (doLdr | doStr) ? Address : '0;
      DataBus       <= doStr ? Data : '0;
    end
  end

`ifdef MEMCTRL_ALIGN_CHECK_EN
  // One-cycle flag for an LDR/STR whose address is not word aligned
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      AlignErr <= 1'b0;
    end else begin
      AlignErr <= ((Opcode == OP_LDR) || (Opcode == OP_STR)) &&
                  (Address[1:0] != 2'b00);
    end
  end
`endif

  // The RAM read register is the load result: it only updates on LDR
  memctrl_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (doStr),
    .re    (doLdr),
    .addr  (idx),
    .wdata (Data),
    .rdata (LDRDataToDestReg)
  );

endmodule

// File: tb/tb_memory_controller.sv
// tb_memory_controller
// Directed bench for memory_controller: reset state, LDR/STR/NOP decode,
// store-then-load, address aliasing, asynchronous reset mid-store and the
// optional alignment check (MEMCTRL_ALIGN_CHECK_EN).
module tb_memory_controller;

  logic        clk;
  logic        rst_n;
  logic [3:0]  Opcode;
  logic [31:0] Address;
  logic [31:0] Data;
  logic        LDRSel;
  logic        AddressBusSel;
  logic        RW;
  logic [31:0] LDRDataToDestReg;
  logic [31:0] AddressBus;
  logic [31:0] DataBus;
`ifdef MEMCTRL_ALIGN_CHECK_EN
  logic        AlignErr;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [3:0] LDR = 4'b1101;
  localparam logic [3:0] STR = 4'b1110;
  localparam logic [3:0] NOP = 4'b0000;

  memory_controller #(.DEPTH(256)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .Opcode           (Opcode),
    .Address          (Address),
    .Data             (Data),
    .LDRSel           (LDRSel),
    .AddressBusSel    (AddressBusSel),
    .RW               (RW),
    .LDRDataToDestReg (LDRDataToDestReg),
    .AddressBus       (AddressBus),
    .DataBus          (DataBus)
`ifdef MEMCTRL_ALIGN_CHECK_EN
    ,
    .AlignErr         (AlignErr)
`endif
  );

  // 10 time-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one opcode and let it be sampled; returns 1 unit after the edge
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] addr,
                               input logic [31:0] data);
    Opcode  = op;
    Address = addr;
    Data    = data;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic ldrSel,
                          input logic busSel, input logic rw,
                          input logic [31:0] ldrData,
                          input logic [31:0] addrBus,
                          input logic [31:0] dataBus);
    checkOutput({tag, ".LDRSel"}, {31'd0, LDRSel}, {31'd0, ldrSel});
    checkOutput({tag, ".AddressBusSel"}, {31'd0, AddressBusSel}, {31'd0, busSel});
    checkOutput({tag, ".RW"}, {31'd0, RW}, {31'd0, rw});
    checkOutput({tag, ".LDRData"}, LDRDataToDestReg, ldrData);
    checkOutput({tag, ".AddressBus"}, AddressBus, addrBus);
    checkOutput({tag, ".DataBus"}, DataBus, dataBus);
  endtask

  initial begin
    rst_n   = 1'b0;
    Opcode  = NOP;
    Address = '0;
    Data    = '0;
    repeat (2) @(posedge clk);
    #1;
    checkAll("reset", 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
    rst_n = 1'b1;

    // Load from cleared RAM
    applyStimulus(LDR, 32'h12345678, 32'h9abcdef0);
    checkAll("ldr0", 1'b1, 1'b1, 1'b1, 32'h0, 32'h12345678, 32'h0);

    // Store; load data holds
    applyStimulus(STR, 32'h12345678, 32'h9abcdef0);
    checkAll("str0", 1'b0, 1'b1, 1'b0, 32'h0, 32'h12345678, 32'h9abcdef0);

    // Load right after the store returns the new word
    applyStimulus(LDR, 32'h12345678, 32'h0);
    checkAll("ldr1", 1'b1, 1'b1, 1'b1, 32'h9abcdef0, 32'h12345678, 32'h0);

    // Alias: +0x400 wraps back to the same index with DEPTH=256
    applyStimulus(LDR, 32'h12345a78, 32'h0);
    checkAll("alias", 1'b1, 1'b1, 1'b1, 32'h9abcdef0, 32'h12345a78, 32'h0);

    // NOP clears the buses, load data holds
    applyStimulus(NOP, 32'hffffffff, 32'hffffffff);
    checkAll("nop", 1'b0, 1'b0, 1'b1, 32'h9abcdef0, 32'h0, 32'h0);

    // Another undefined opcode is also a NOP
    applyStimulus(4'b1111, 32'h00000004, 32'h55555555);
    checkAll("nopF", 1'b0, 1'b0, 1'b1, 32'h9abcdef0, 32'h0, 32'h0);

    // Distinct index: store to word 1, word 0 still empty
    applyStimulus(STR, 32'h00000004, 32'h11111111);
    checkAll("str1", 1'b0, 1'b1, 1'b0, 32'h9abcdef0, 32'h00000004, 32'h11111111);
    applyStimulus(LDR, 32'h00000000, 32'h0);
    checkOutput("ldrWord0", LDRDataToDestReg, 32'h0);
    applyStimulus(LDR, 32'h00000004, 32'h0);
    checkOutput("ldrWord1", LDRDataToDestReg, 32'h11111111);

`ifdef MEMCTRL_ALIGN_CHECK_EN
    // Misaligned load is squashed and flagged for one cycle
    applyStimulus(LDR, 32'h00000001, 32'h0);
    checkAll("misLdr", 1'b0, 1'b0, 1'b1, 32'h11111111, 32'h0, 32'h0);
    checkOutput("misLdr.AlignErr", {31'd0, AlignErr}, 32'd1);
    applyStimulus(NOP, 32'h0, 32'h0);
    checkOutput("alignClr", {31'd0, AlignErr}, 32'd0);
`else
    // Low address bits ignored: 0x7 reads word 1
    applyStimulus(LDR, 32'h00000007, 32'h0);
    checkAll("lowBits", 1'b1, 1'b1, 1'b1, 32'h11111111, 32'h00000007, 32'h0);
`endif

    // Reset mid-STR: outputs clear without waiting for an edge
    applyStimulus(STR, 32'h12345678, 32'hdeadbeef);
    checkAll("str2", 1'b0, 1'b1, 1'b0, 32'h11111111, 32'h12345678, 32'hdeadbeef);
    #2;
    rst_n = 1'b0;
    #1;
    checkAll("asyncRst", 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    checkAll("holdRst", 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
    Opcode = NOP;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // RAM was cleared by reset
    applyStimulus(LDR, 32'h12345678, 32'h0);
    checkAll("ldrAfterRst", 1'b1, 1'b1, 1'b1, 32'h0, 32'h12345678, 32'h0);
    applyStimulus(LDR, 32'h00000004, 32'h0);
    checkOutput("ldrWord1Rst", LDRDataToDestReg, 32'h0);

`ifdef MEMCTRL_ALIGN_CHECK_EN
    // Misaligned store does not write and load data holds
    applyStimulus(STR, 32'h12345679, 32'h77777777);
    checkOutput("misStr.AlignErr", {31'd0, AlignErr}, 32'd1);
    checkOutput("misStr.RW", {31'd0, RW}, 32'd1);
    applyStimulus(LDR, 32'h12345678, 32'h0);
    checkOutput("misStrNoWrite", LDRDataToDestReg, 32'h0);
    applyStimulus(LDR, 32'h12345679, 32'h0);
    checkOutput("misLdrHeld", LDRDataToDestReg, 32'h0);
    checkOutput("misLdr2.AlignErr", {31'd0, AlignErr}, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
